// File: rtl/toy_phy_reg_prealloc_buffer_if.sv
// Pre-allocate / rename / cancel signal bundle between the free list, the rename stage and
// the phys-reg pre-allocate buffer.
interface toy_phy_reg_prealloc_buffer_if #(
    parameter int unsigned INST_DECODE_NUM  = 4,
    parameter int unsigned PHY_REG_ID_WIDTH = 7,
    parameter int unsigned PHY_REG_NUM      = 128,
    parameter int unsigned DEPTH            = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [INST_DECODE_NUM-1:0]                       v_pre_allocate_vld;
    logic [INST_DECODE_NUM-1:0][PHY_REG_ID_WIDTH-1:0] v_pre_allocate_id;
    logic [INST_DECODE_NUM-1:0]                       v_pre_allocate_rdy;
    logic [INST_DECODE_NUM-1:0]                       v_rename_req;
    logic                                             rename_gnt;
    logic [INST_DECODE_NUM-1:0][PHY_REG_ID_WIDTH-1:0] v_rename_phy_id;
    logic [CW-1:0]                                    buf_cnt;
    logic [PHY_REG_NUM-1:0]                           v_phy_release_flush;
    logic                                             cancel_en;
    logic                                             cancel_edge_en;

    modport master (
        output v_pre_allocate_vld, v_pre_allocate_id, v_rename_req, cancel_en, cancel_edge_en,
        input  v_pre_allocate_rdy, rename_gnt, v_rename_phy_id, buf_cnt, v_phy_release_flush
    );

    modport slave (
        input  v_pre_allocate_vld, v_pre_allocate_id, v_rename_req, cancel_en, cancel_edge_en,
        output v_pre_allocate_rdy, rename_gnt, v_rename_phy_id, buf_cnt, v_phy_release_flush
    );
endinterface

// File: rtl/toy_phy_reg_prealloc_buffer.sv
// Circular buffer of pre-allocated phys-reg IDs: compacting multi-lane enqueue from the free
// list, all-or-nothing lane-ordered dequeue to rename, and bitmap release on cancel.
module toy_phy_reg_prealloc_buffer #(
    parameter int unsigned INST_DECODE_NUM  = 4,
    parameter int unsigned PHY_REG_ID_WIDTH = 7,
    parameter int unsigned PHY_REG_NUM      = 128,
    parameter int unsigned DEPTH            = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    toy_phy_reg_prealloc_buffer_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LANES_C = CW'(INST_DECODE_NUM);

    typedef logic [PHY_REG_ID_WIDTH-1:0] id_t;

    id_t                    r_mem [DEPTH];
    logic [AW-1:0]          r_head;
    logic [AW-1:0]          r_tail;
    logic [CW-1:0]          r_cnt;
    logic [PHY_REG_NUM-1:0] r_flush;

    logic                                             w_rdy;
    logic                                             w_gnt;
    logic [INST_DECODE_NUM-1:0]                       w_enq;
    logic [CW-1:0]                                    w_enq_n;
    logic [CW-1:0]                                    w_req_n;
    logic [CW-1:0]                                    w_enq_off [INST_DECODE_NUM];
    logic [CW-1:0]                                    w_req_off [INST_DECODE_NUM];
    logic [INST_DECODE_NUM-1:0][PHY_REG_ID_WIDTH-1:0] w_ren_id;
    logic [PHY_REG_NUM-1:0]                           w_bitmap;
    logic                                             w_dup;

    // Readiness depends only on the registered count so the free list sees no comb loop.
    always_comb begin
        w_rdy   = ((DEPTH_C - r_cnt) >= LANES_C) && !bus.cancel_en;
        w_enq   = bus.v_pre_allocate_vld & {INST_DECODE_NUM{w_rdy}};
        w_enq_n = '0;
        w_req_n = '0;
        for (int unsigned i = 0; i < INST_DECODE_NUM; i++) begin
            w_enq_off[i] = w_enq_n;
            w_req_off[i] = w_req_n;
            w_enq_n      = w_enq_n + CW'(w_enq[i]);
            w_req_n      = w_req_n + CW'(bus.v_rename_req[i]);
        end
        w_gnt = (w_req_n != '0) && !bus.cancel_en && (r_cnt >= w_req_n);
        for (int unsigned i = 0; i < INST_DECODE_NUM; i++) begin
            w_ren_id[i] = (w_gnt && bus.v_rename_req[i]) ?
                          r_mem[r_head + AW'(w_req_off[i])] : '0;
        end
    end

    always_comb begin
        w_bitmap = '0;
        w_dup    = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (CW'(k) < r_cnt) begin
                w_bitmap[r_mem[r_head + AW'(k)]] = 1'b1;
            end
            for (int unsigned m = k + 1; m < DEPTH; m++) begin
                if ((CW'(m) < r_cnt) && (r_mem[r_head + AW'(k)] == r_mem[r_head + AW'(m)])) begin
                    w_dup = 1'b1;
                end
            end
        end
    end

    // Entry storage carries no reset; validity is tracked purely by head/count.
    always_ff @(posedge clk) begin
        if (!bus.cancel_edge_en) begin
            for (int unsigned i = 0; i < INST_DECODE_NUM; i++) begin
                if (w_enq[i]) begin
                    r_mem[r_tail + AW'(w_enq_off[i])] <= bus.v_pre_allocate_id[i];
                end
            end
        end
    end

    // A cancel edge overrides same-cycle enqueue/dequeue and empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_cnt   <= '0;
            r_flush <= '0;
        end else if (bus.cancel_edge_en) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_cnt   <= '0;
            r_flush <= w_bitmap;
        end else begin
            r_flush <= '0;
            r_tail  <= r_tail + AW'(w_enq_n);
            if (w_gnt) begin
                r_head <= r_head + AW'(w_req_n);
            end
            r_cnt <= r_cnt + w_enq_n - (w_gnt ? w_req_n : '0);
        end
    end

    assign bus.v_pre_allocate_rdy  = {INST_DECODE_NUM{w_rdy}};
    assign bus.rename_gnt          = w_gnt;
    assign bus.v_rename_phy_id     = w_ren_id;
    assign bus.buf_cnt             = r_cnt;
    assign bus.v_phy_release_flush = r_flush;

    a_cnt_bound : assert property (@(posedge clk) disable iff (!rst_n) r_cnt <= DEPTH_C);
    a_no_dup    : assert property (@(posedge clk) disable iff (!rst_n) !w_dup);
endmodule
